// File: rtl/mwc_pkg.sv
// Shared types for the memory-write checker: run-state encoding and fail codes.
package mwc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_BAD_ADR  = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_BAD_DATA = 2'd3;

endpackage

// File: rtl/mwc_table.sv
// Expected-write table: DEPTH {address, data} registers, one write port, one
// asynchronous read port. Contents are deliberately not reset so a run can be repeated.
module mwc_table #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int IW     = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_idx,
    input  logic [ADDR_W-1:0] wr_adr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IW-1:0]     rd_idx,
    output logic [ADDR_W-1:0] rd_adr,
    output logic [DATA_W-1:0] rd_data
);

    logic [ADDR_W-1:0] adr_q  [DEPTH];
    logic [ADDR_W-1:0] adr_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    always_comb begin
        adr_d  = adr_q;
        data_d = data_q;
        if (wr_en && (32'(wr_idx) < DEPTH)) begin
            adr_d[wr_idx]  = wr_adr;
            data_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        adr_q  <= adr_d;
        data_q <= data_d;
    end

    assign rd_adr  = adr_q[rd_idx];
    assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/mem_write_checker.sv
// Watches a store bus and checks that the first num_checks table entries are
// written in order, with optional timeout; reports PASS or FAIL with a reason.
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 32,
    parameter int                DEPTH   = 8,
    parameter int                TMO_W   = 16,
    parameter logic [ADDR_W-1:0] IGN_ADR = ADDR_W'(96),
    parameter bit                STRICT  = 1'b1,
    localparam int               IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_idx,
    input  logic [ADDR_W-1:0] cfg_adr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              start,
    input  logic [IW:0]       num_checks,
    input  logic [TMO_W-1:0]  tmo_limit,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [IW-1:0]     fail_idx,
    output logic [TMO_W-1:0]  cycles
);

    localparam logic [IW:0]      MAX_N   = (IW+1)'(DEPTH);
    localparam logic [IW:0]      ONE_N   = (IW+1)'(1);
    localparam logic [IW-1:0]    IDX_ONE = IW'(1);
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW:0]       num_q, num_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [TMO_W-1:0]  cycles_q, cycles_d;
    logic [1:0]        fail_code_q, fail_code_d;
    logic [IW-1:0]     fail_idx_q, fail_idx_d;

    logic [ADDR_W-1:0] ent_adr;
    logic [DATA_W-1:0] ent_data;
    logic [IW:0]       num_clamped;
    logic              wr_live, adr_hit, full_hit, is_last, timed_out;

    mwc_table #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_table (
        .clk    (clk),
        .wr_en  (cfg_we && (state_q != ST_RUN)),
        .wr_idx (cfg_idx),
        .wr_adr (cfg_adr),
        .wr_data(cfg_data),
        .rd_idx (idx_q),
        .rd_adr (ent_adr),
        .rd_data(ent_data)
    );

    // start and MemWrite are single-cycle strobes sampled on the rising edge; there
    // is no back-pressure, so every strobe seen in RUN is judged in that same cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        num_d       = num_q;
        tmo_d       = tmo_q;
        cycles_d    = cycles_q;
        fail_code_d = fail_code_q;
        fail_idx_d  = fail_idx_q;

        num_clamped = (num_checks > MAX_N) ? MAX_N : num_checks;
        wr_live     = MemWrite && (DataAdr != IGN_ADR);
        adr_hit     = (DataAdr == ent_adr);
        full_hit    = wr_live && adr_hit && (WriteData == ent_data);
        is_last     = ({1'b0, idx_q} + ONE_N) == num_q;
        timed_out   = (tmo_q != '0) && (cycles_q == tmo_q - TMO_ONE);

        case (state_q)
            ST_RUN: begin
                if (!(&cycles_q)) begin
                    cycles_d = cycles_q + TMO_ONE;
                end
                if (full_hit) begin
                    idx_d = idx_q + IDX_ONE;
                end
                // Final match beats a same-cycle timeout; a bad write beats a timeout.
                if (full_hit && is_last) begin
                    state_d = ST_PASS;
                end else if (wr_live && !full_hit && STRICT) begin
                    state_d     = ST_FAIL;
                    fail_code_d = adr_hit ? FC_BAD_DATA : FC_BAD_ADR;
                    fail_idx_d  = idx_q;
                end else if (timed_out) begin
                    state_d     = ST_FAIL;
                    fail_code_d = FC_TIMEOUT;
                    fail_idx_d  = idx_d;
                    cycles_d    = cycles_q;
                end
            end
            default: begin
                if (start) begin
                    num_d       = num_clamped;
                    tmo_d       = tmo_limit;
                    idx_d       = '0;
                    cycles_d    = '0;
                    fail_code_d = FC_NONE;
                    fail_idx_d  = '0;
                    state_d     = (num_clamped == '0) ? ST_PASS : ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            num_q       <= '0;
            tmo_q       <= '0;
            cycles_q    <= '0;
            fail_code_q <= FC_NONE;
            fail_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            num_q       <= num_d;
            tmo_q       <= tmo_d;
            cycles_q    <= cycles_d;
            fail_code_q <= fail_code_d;
            fail_idx_q  <= fail_idx_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_PASS) || (state_q == ST_FAIL);
    assign pass      = (state_q == ST_PASS);
    assign fail_code = fail_code_q;
    assign fail_idx  = fail_idx_q;
    assign cycles    = cycles_q;

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the monitored write-data bus.
REQ-002 SHALL have parameter ADDR_W, default 32, width of the monitored address bus.
REQ-003 SHALL have parameter DEPTH, default 8, number of expected-write table entries; IW = clog2(DEPTH).
REQ-004 SHALL have parameter TMO_W, default 16, width of the timeout limit and cycle counter.
REQ-005 SHALL have parameter IGN_ADR, default 96, scratch address whose writes are always ignored.
REQ-006 SHALL have parameter STRICT, default 1; 1 = any unexpected write fails the run, 0 = unexpected writes are ignored.
REQ-007 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 MemWrite  in  1  monitored store strobe.
REQ-010 DataAdr  in  ADDR_W  monitored store address.
REQ-011 WriteData  in  DATA_W  monitored store data.
REQ-012 cfg_we / cfg_idx / cfg_adr / cfg_data  in  1 / IW / ADDR_W / DATA_W  table write port.
REQ-013 start  in  1  one-cycle run request; num_checks  in  IW+1; tmo_limit  in  TMO_W (0 = no timeout).
REQ-014 busy, done, pass  out  1 each; fail_code  out  2; fail_idx  out  IW; cycles  out  TMO_W.

Function
REQ-015 SHALL implement states IDLE, RUN, PASS, FAIL; busy = RUN, done = PASS or FAIL, pass = PASS.
REQ-016 cfg_we SHALL write entry cfg_idx when not in RUN; cfg_we in RUN SHALL be ignored.
REQ-017 start in IDLE/PASS/FAIL SHALL latch num_checks and tmo_limit, clear idx, cycles, fail_code, fail_idx, and enter RUN next cycle; start in RUN SHALL be ignored.
REQ-018 start with num_checks = 0 SHALL go directly to PASS; num_checks > DEPTH SHALL be clamped to DEPTH.
REQ-019 In RUN, cycles SHALL increment every cycle, saturating at all-ones.
REQ-020 In RUN, MemWrite with DataAdr = IGN_ADR SHALL be ignored.
REQ-021 MemWrite with DataAdr and WriteData equal to entry[idx] SHALL advance idx; if that match is entry num_checks-1, next state SHALL be PASS.
REQ-022 MemWrite with DataAdr = entry[idx].adr but WriteData different SHALL, if STRICT, go to FAIL with fail_code 3 (BAD_DATA), fail_idx = idx.
REQ-023 MemWrite with any other address SHALL, if STRICT, go to FAIL with fail_code 1 (BAD_ADR), fail_idx = idx; if not STRICT both cases are ignored.
REQ-024 With tmo_limit != 0, RUN reaching cycles = tmo_limit-1 without completing SHALL go to FAIL, fail_code 2 (TIMEOUT).
REQ-025 Final match and timeout in the same cycle: match SHALL win (PASS).
REQ-026 PASS/FAIL SHALL hold all outputs, including cycles, until start or reset.
REQ-027 Comparisons SHALL be full-width, exact; no X-tolerant matching.

Reset
REQ-028 reset SHALL force IDLE, busy/done/pass = 0, fail_code = 0, fail_idx = 0, cycles = 0, idx = 0, including mid-RUN.
REQ-029 Table contents SHALL NOT be cleared by reset.

Structure
REQ-030 Package mwc_pkg SHALL hold the state enum and fail-code constants (NONE 0, BAD_ADR 1, TIMEOUT 2, BAD_DATA 3).
REQ-031 Table SHALL be a sub-module mwc_table (DEPTH x {adr,data} registers, one write port, one async read port at idx).

Verification
REQ-032 entry0 = (100,25), num 1, STRICT: writes (96,7) then (100,25) -> pass = 1, fail_code 0.
REQ-033 Same config, write (100,7) -> FAIL, fail_code 3, fail_idx 0.
REQ-034 Same config, write (104,25) -> FAIL code 1; with STRICT = 0 -> ignored, later (100,25) passes.
REQ-035 tmo_limit 50, no writes -> FAIL code 2 with cycles = 49.
REQ-036 Three entries (100,1),(104,2),(108,3), writes in order -> PASS; reset asserted after second match -> IDLE, all outputs 0, table retained, restart passes.
